// File: rtl/rf_pkg.sv
// Shared definitions for the general-purpose register file: x86 register indices,
// the clear-sequencer state type and the select-to-byte-lane decode.
package rf_pkg;

  // 16-bit register indices
  localparam int AX = 0;
  localparam int CX = 1;
  localparam int DX = 2;
  localparam int BX = 3;
  localparam int SP = 4;
  localparam int BP = 5;
  localparam int SI = 6;
  localparam int DI = 7;

  // 8-bit register selects
  localparam int AL = 0;
  localparam int CL = 1;
  localparam int DL = 2;
  localparam int BL = 3;
  localparam int AH = 4;
  localparam int CH = 5;
  localparam int DH = 6;
  localparam int BH = 7;

  localparam int IDX_W = 8;

  localparam logic [1:0] LANE_LO   = 2'b01;
  localparam logic [1:0] LANE_HI   = 2'b10;
  localparam logic [1:0] LANE_FULL = 2'b11;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

  typedef struct packed {
    logic [IDX_W-1:0] reg_idx;
    logic [1:0]       lane_mask;
  } lane_sel_t;

  // LANE_HI in 8-bit mode means bits [15:8]; LANE_FULL means the whole register.
  function automatic lane_sel_t byte_lane_of(input logic [IDX_W-1:0] sel, input logic is_8_bit);
    lane_sel_t r;
    if (is_8_bit) begin
      r.reg_idx   = {{(IDX_W-2){1'b0}}, sel[1:0]};
      r.lane_mask = sel[2] ? LANE_HI : LANE_LO;
    end else begin
      r.reg_idx   = sel;
      r.lane_mask = LANE_FULL;
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_write_merge.sv
// Next-state register array: current contents with every enabled write port merged in
// byte-lane by byte-lane; later ports override earlier ones on overlapping bytes.
module rf_write_merge
  import rf_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int NUM_WR   = 1,
  parameter int ADDR_W   = 3
) (
  input  logic [WIDTH-1:0]  gprs     [NUM_REGS],
  input  logic              wr_allow,
  input  logic              is_8_bit,
  input  logic [ADDR_W-1:0] wr_sel   [NUM_WR],
  input  logic [WIDTH-1:0]  wr_val   [NUM_WR],
  input  logic [NUM_WR-1:0] wr_en,
  output logic [WIDTH-1:0]  merged   [NUM_REGS]
);

  lane_sel_t        wr_lane [NUM_WR];
  logic [WIDTH-1:0] wr_mask [NUM_WR];
  logic [WIDTH-1:0] wr_data [NUM_WR];

  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr
    assign wr_lane[gi] = byte_lane_of(IDX_W'(wr_sel[gi]), is_8_bit);
    assign wr_mask[gi] = (wr_lane[gi].lane_mask == LANE_FULL) ? '1 :
                         (wr_lane[gi].lane_mask == LANE_HI)   ? WIDTH'(16'hFF00) :
                                                                WIDTH'(16'h00FF);
    // 8-bit data always arrives on [7:0] and is steered onto the addressed lane
    assign wr_data[gi] = (wr_lane[gi].lane_mask == LANE_FULL) ? wr_val[gi] :
                         (wr_lane[gi].lane_mask == LANE_HI)   ? WIDTH'({wr_val[gi][7:0], 8'h00}) :
                                                                WIDTH'(wr_val[gi][7:0]);
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      merged[r] = gprs[r];
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_allow && wr_en[p] && (wr_lane[p].reg_idx == IDX_W'(r))) begin
          merged[r] = (merged[r] & ~wr_mask[p]) | (wr_data[p] & wr_mask[p]);
        end
      end
    end
  end

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file with x86 8-bit lane addressing, write-to-read bypass through the
// merged next state, and a post-reset clear sequencer that zeroes one register per cycle.
module gpr_file_mp
  import rf_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              is_8_bit,
  input  logic [ADDR_W-1:0] rd_sel [NUM_RD],
  output logic [WIDTH-1:0]  rd_val [NUM_RD],
  input  logic [ADDR_W-1:0] wr_sel [NUM_WR],
  input  logic [WIDTH-1:0]  wr_val [NUM_WR],
  input  logic [NUM_WR-1:0] wr_en,
  output logic [WIDTH-1:0]  taps   [NUM_REGS],
  output logic              busy
);

  rf_state_t        state;
  logic [ADDR_W-1:0] clr_idx;
  logic [WIDTH-1:0] gprs      [NUM_REGS];
  logic [WIDTH-1:0] merged    [NUM_REGS];
  logic [WIDTH-1:0] gprs_next [NUM_REGS];
  logic [WIDTH-1:0] rd_data   [NUM_RD];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_idx == ADDR_W'(NUM_REGS - 1)) begin
            state <= READY;
            busy  <= 1'b0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        READY:   ;
        default: state <= CLEAR;
      endcase
    end
  end

  rf_write_merge #(
    .WIDTH   (WIDTH),
    .NUM_REGS(NUM_REGS),
    .NUM_WR  (NUM_WR),
    .ADDR_W  (ADDR_W)
  ) u_merge (
    .gprs    (gprs),
    .wr_allow(state == READY),
    .is_8_bit(is_8_bit),
    .wr_sel  (wr_sel),
    .wr_val  (wr_val),
    .wr_en   (wr_en),
    .merged  (merged)
  );

  // The register being cleared reads as zero in the same cycle it is cleared.
  always_comb begin
    gprs_next = merged;
    if (state == CLEAR) gprs_next[clr_idx] = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) gprs <= gprs_next;
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    lane_sel_t        rd_lane;
    logic [WIDTH-1:0] word;

    assign rd_lane = byte_lane_of(IDX_W'(rd_sel[gi]), is_8_bit);

    always_comb begin
      word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rd_lane.reg_idx == IDX_W'(i)) word = gprs_next[i];
      end
    end

    assign rd_data[gi] = (rd_lane.lane_mask == LANE_FULL) ? word :
                         (rd_lane.lane_mask == LANE_HI)   ? WIDTH'(word[15:8]) :
                                                            WIDTH'(word[7:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) taps[i] <= '0;
      for (int r = 0; r < NUM_RD; r++) rd_val[r] <= '0;
    end else begin
      taps <= gprs_next;
      for (int r = 0; r < NUM_RD; r++) rd_val[r] <= rd_data[r];
    end
  end

  // 8-bit mode only reaches AL..BH.
  always_ff @(posedge clk) begin
    if (!reset && is_8_bit) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p]) assert ((wr_sel[p] >> 3) == '0);
      end
      for (int r = 0; r < NUM_RD; r++) assert ((rd_sel[r] >> 3) == '0);
    end
  end

endmodule
